ft_write_voter: RTL and testbench

Parametrised N-channel write-transaction voter for the fault-tolerant SoC, placed between the data-memory ports of N redundant zeroriscy cores and the single data memory. Each core's store is buffered in its own FIFO. Matching stores are aligned across channels, majority-voted and forwarded once over a valid/ready port. Disagreeing, late or missing channels are flagged. N_CH=2 gives the DMR compare-and-stop case; N_CH>=3 gives TMR-style masking.

---
 rtl/ft_write_voter_if.sv | 30 +++
 rtl/ft_write_voter.sv | 199 +++++++++++++++++++
 tb/tb_ft_write_voter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft_write_voter_if.sv
// Store bundle between redundant cores, the voter and data memory.
// slave: voter side; master: cores + memory side (bench drives it).
interface ft_write_voter_if #(
  parameter int N_CH   = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic [N_CH-1:0]        ch_valid_i;
  logic [N_CH-1:0]        ch_ready_o;
  logic [N_CH*ADDR_W-1:0] ch_addr_i;
  logic [N_CH*DATA_W-1:0] ch_data_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [ADDR_W-1:0]      out_addr_o;
  logic [DATA_W-1:0]      out_data_o;

  modport slave (
    input  ch_valid_i, ch_addr_i, ch_data_i,
    input  out_ready_i,
    output ch_ready_o, out_valid_o,
    output out_addr_o, out_data_o
  );

  modport master (
    output ch_valid_i, ch_addr_i, ch_data_i,
    output out_ready_i,
    input  ch_ready_o, out_valid_o,
    input  out_addr_o, out_data_o
  );
endinterface

// File: rtl/ft_write_voter.sv
// ft_write_voter: per-channel store FIFOs, head alignment with skew
// timeout, majority vote into one output register, sticky fault flags.
// Ports: clk_i, rst_i (async, active-high), bus (ft_write_voter_if
// slave: channel valid/ready/addr/data in, voted store out),
// clr_i, err_mask_o, timeout_o, fatal_o, err_cnt_o.
// Macro FT_VOTER_STATS_EN builds the saturating fault counter;
// without it err_cnt_o is tied to 0.
module ft_write_voter #(
  parameter int N_CH     = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int SKEW_MAX = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ft_write_voter_if.slave  bus,
  input  logic             clr_i,
  output logic [N_CH-1:0]  err_mask_o,
  output logic             timeout_o,
  output logic             fatal_o,
  output logic [7:0]       err_cnt_o
);
  localparam int W  = ADDR_W + DATA_W;
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(SKEW_MAX + 1);
  localparam int CW = $clog2(N_CH + 1);
  localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);
  localparam logic [TW-1:0] TMAX = TW'(SKEW_MAX);
  localparam logic [CW-1:0] HALF = CW'(N_CH / 2);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_HOLD
  } state_t;

  logic [W-1:0]  r_mem [N_CH][DEPTH];
  logic [PW-1:0] r_wp  [N_CH];
  logic [PW-1:0] r_rp  [N_CH];
  logic [PW:0]   r_cnt [N_CH];

  state_t          r_st;
  logic [TW-1:0]   r_tmr;
  logic            r_ov;
  logic [ADDR_W-1:0] r_oa;
  logic [DATA_W-1:0] r_od;
  logic [N_CH-1:0] r_mask;
  logic            r_tmo;
  logic            r_fatal;

  logic [N_CH-1:0] w_rdy, w_push, w_pres, w_pop, w_flag;
  logic [W-1:0]    w_head   [N_CH];
  logic [PW:0]     w_cnt_nx [N_CH];
  logic [W-1:0]    w_win;
  logic [CW-1:0]   w_n;
  logic w_win_ok, w_free, w_all, w_any;
  logic w_tmo, w_vote, w_more;

  genvar g;
  for (g = 0; g < N_CH; g++) begin : g_ch
    assign w_pres[g]   = r_cnt[g] != '0;
    assign w_head[g]   = r_mem[g][r_rp[g]];
    // Registered count only: a full FIFO refuses a push even while popping.
    assign w_rdy[g]    = r_cnt[g] != FULL;
    assign w_push[g]   = bus.ch_valid_i[g] & w_rdy[g];
    assign w_pop[g]    = w_vote & w_pres[g];
    assign w_cnt_nx[g] = r_cnt[g] + (PW+1)'(w_push[g])
                       - (PW+1)'(w_pop[g]);
  end

  assign bus.ch_ready_o  = w_rdy;
  assign bus.out_valid_o = r_ov;
  assign bus.out_addr_o  = r_oa;
  assign bus.out_data_o  = r_od;
  assign err_mask_o      = r_mask;
  assign timeout_o       = r_tmo;
  assign fatal_o         = r_fatal;

  assign w_free = !r_ov | bus.out_ready_i;
  assign w_all  = &w_pres;
  assign w_any  = |w_pres;
  assign w_tmo  = (r_st != S_IDLE) & (r_tmr == TMAX);
  assign w_vote = w_free & w_any & (w_all | w_tmo);

  // Scan high to low so the lowest-index majority head wins.
  always_comb begin
    w_win    = '0;
    w_win_ok = 1'b0;
    w_flag   = '0;
    w_n      = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      w_n = '0;
      for (int i = 0; i < N_CH; i++)
        if (w_pres[i] && w_head[i] == w_head[j])
          w_n = w_n + CW'(1);
      if (w_pres[j] && w_n > HALF) begin
        w_win    = w_head[j];
        w_win_ok = 1'b1;
      end
    end
    for (int i = 0; i < N_CH; i++)
      w_flag[i] = !w_pres[i] ||
                  (w_win_ok && w_head[i] != w_win);
  end

  always_comb begin
    w_more = 1'b0;
    for (int i = 0; i < N_CH; i++)
      w_more = w_more | (w_cnt_nx[i] != '0);
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_CH; i++)
      if (w_push[i])
        r_mem[i][r_wp[i]] <= {bus.ch_addr_i[i*ADDR_W +: ADDR_W],
                              bus.ch_data_i[i*DATA_W +: DATA_W]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_CH; i++) begin
        r_wp[i]  <= '0;
        r_rp[i]  <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_push[i]) r_wp[i] <= r_wp[i] + PW'(1);
        if (w_pop[i])  r_rp[i] <= r_rp[i] + PW'(1);
        r_cnt[i] <= w_cnt_nx[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_st    <= S_IDLE;
      r_tmr   <= '0;
      r_ov    <= 1'b0;
      r_oa    <= '0;
      r_od    <= '0;
      r_mask  <= '0;
      r_tmo   <= 1'b0;
      r_fatal <= 1'b0;
    end else begin
      // A vote with a partial set can only have been forced by the timer.
      r_tmo <= w_vote & !w_all;
      if (!w_free) begin
        r_st <= S_HOLD;
      end else if (w_vote) begin
        r_tmr <= '0;
        r_st  <= w_more ? S_WAIT : S_IDLE;
      end else if (w_any) begin
        r_tmr <= r_tmr + TW'(1);
        r_st  <= S_WAIT;
      end else begin
        r_tmr <= '0;
        r_st  <= S_IDLE;
      end

      if (w_vote && w_win_ok) begin
        r_ov         <= 1'b1;
        {r_oa, r_od} <= w_win;
      end else if (bus.out_ready_i) begin
        r_ov <= 1'b0;
      end

      // A fault seen with clr_i survives the clear.
      if (w_vote) begin
        r_mask  <= (clr_i ? '0 : r_mask) | w_flag;
        r_fatal <= (!clr_i & r_fatal) | !w_win_ok;
      end else if (clr_i) begin
        r_mask  <= '0;
        r_fatal <= 1'b0;
      end
    end
  end

`ifdef FT_VOTER_STATS_EN
  logic       w_fault;
  logic [7:0] w_ebase;
  logic [7:0] r_ecnt;

  assign w_fault = (|w_flag) | !w_win_ok;
  assign w_ebase = clr_i ? 8'd0 : r_ecnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_ecnt <= '0;
    else if (w_vote && w_fault && w_ebase != 8'hFF)
      r_ecnt <= w_ebase + 8'd1;
    else if (clr_i)
      r_ecnt <= '0;
  end

  assign err_cnt_o = r_ecnt;
`else
  assign err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_ft_write_voter.sv
// Bench for ft_write_voter: queue-based reference model for a 3-channel
// voter checked every cycle, plus literal checks on 3- and 2-channel builds.
module tb_ft_write_voter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int DEP = 4;
  localparam int SK  = 8;
`ifdef FT_VOTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic clr2 = 1'b0;
  always #5 clk = ~clk;

  ft_write_voter_if #(.N_CH(3), .ADDR_W(AW), .DATA_W(DW)) b3 ();
  ft_write_voter_if #(.N_CH(2), .ADDR_W(AW), .DATA_W(DW)) b2 ();

  logic [2:0] mask3;
  logic       tmo3, fat3;
  logic [7:0] cnt3;
  logic [1:0] mask2;
  logic       tmo2, fat2;
  logic [7:0] cnt2;

  ft_write_voter #(
    .N_CH(3), .ADDR_W(AW), .DATA_W(DW),
    .DEPTH(DEP), .SKEW_MAX(SK)
  ) u3 (
    .clk_i(clk), .rst_i(rst), .bus(b3), .clr_i(clr),
    .err_mask_o(mask3), .timeout_o(tmo3),
    .fatal_o(fat3), .err_cnt_o(cnt3)
  );

  ft_write_voter #(
    .N_CH(2), .ADDR_W(AW), .DATA_W(DW),
    .DEPTH(DEP), .SKEW_MAX(SK)
  ) u2 (
    .clk_i(clk), .rst_i(rst), .bus(b2), .clr_i(clr2),
    .err_mask_o(mask2), .timeout_o(tmo2),
    .fatal_o(fat2), .err_cnt_o(cnt2)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: FIFOs as queues, vote by counting equal heads.
  logic [63:0] mq [3][$];
  bit          mv = 1'b0;
  logic [31:0] ma = '0;
  logic [31:0] md = '0;
  logic [2:0]  mmask = '0;
  bit          mtmo = 1'b0;
  bit          mfat = 1'b0;
  int          mcnt = 0;
  int          age = 0;

  task automatic mstep();
    bit pres [3];
    bit rdy [3];
    bit all, any, free, vote, win_ok, flt;
    logic [63:0] win;
    logic [2:0] flg;
    int n;
    if (rst) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
      mv = 0; ma = '0; md = '0; mmask = '0;
      mtmo = 0; mfat = 0; mcnt = 0; age = 0;
      return;
    end
    all = 1; any = 0;
    for (int i = 0; i < 3; i++) begin
      pres[i] = mq[i].size() > 0;
      rdy[i]  = mq[i].size() < DEP;
      all = all & pres[i];
      any = any | pres[i];
    end
    free = !mv || b3.out_ready_i;
    vote = free && any && (all || age == SK);
    mtmo = vote && !all;
    if (clr) begin
      mmask = '0; mfat = 0; mcnt = 0;
    end
    if (vote) begin
      win_ok = 0; win = '0;
      for (int j = 0; j < 3; j++) begin
        if (pres[j] && !win_ok) begin
          n = 0;
          for (int i = 0; i < 3; i++)
            if (pres[i] && mq[i][0] == mq[j][0]) n++;
          if (n > 3 / 2) begin
            win_ok = 1; win = mq[j][0];
          end
        end
      end
      for (int i = 0; i < 3; i++)
        flg[i] = !pres[i] || (win_ok && mq[i][0] != win);
      flt = (flg != 0) || !win_ok;
      for (int i = 0; i < 3; i++)
        if (pres[i]) void'(mq[i].pop_front());
      if (win_ok) begin
        mv = 1; {ma, md} = win;
      end else if (b3.out_ready_i) begin
        mv = 0;
      end
      mmask = mmask | flg;
      if (!win_ok) mfat = 1;
      if (flt && mcnt < 255) mcnt++;
      age = 0;
    end else begin
      if (b3.out_ready_i) mv = 0;
      if (free) age = any ? age + 1 : 0;
    end
    for (int i = 0; i < 3; i++)
      if (b3.ch_valid_i[i] && rdy[i])
        mq[i].push_back({b3.ch_addr_i[i*AW +: AW],
                         b3.ch_data_i[i*DW +: DW]});
  endtask

  initial begin
    logic [2:0] er;
    forever begin
      @(posedge clk);
      mstep();
      #1;
      for (int i = 0; i < 3; i++) er[i] = mq[i].size() < DEP;
      chk("m_ready", 64'(b3.ch_ready_o), 64'(er));
      chk("m_valid", 64'(b3.out_valid_o), 64'(mv));
      if (mv) begin
        chk("m_addr", 64'(b3.out_addr_o), 64'(ma));
        chk("m_data", 64'(b3.out_data_o), 64'(md));
      end
      chk("m_mask", 64'(mask3), 64'(mmask));
      chk("m_tmo", 64'(tmo3), 64'(mtmo));
      chk("m_fatal", 64'(fat3), 64'(mfat));
      chk("m_cnt", 64'(cnt3), 64'(STATS ? mcnt : 0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic set3(input logic [2:0] v,
                      input logic [31:0] a0, d0, a1, d1, a2, d2);
    b3.ch_valid_i = v;
    b3.ch_addr_i  = {a2, a1, a0};
    b3.ch_data_i  = {d2, d1, d0};
  endtask

  initial begin
    int cyc;
    b3.ch_valid_i = '0; b3.ch_addr_i = '0; b3.ch_data_i = '0;
    b3.out_ready_i = 1'b1;
    b2.ch_valid_i = '0; b2.ch_addr_i = '0; b2.ch_data_i = '0;
    b2.out_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(b3.ch_ready_o), 64'(3'b111));
    chk("rst_valid", 64'(b3.out_valid_o), 64'(0));
    chk("rst_addr", 64'(b3.out_addr_o), 64'(0));
    chk("rst_data", 64'(b3.out_data_o), 64'(0));
    chk("rst_mask", 64'(mask3), 64'(0));
    chk("rst_tmo", 64'(tmo3), 64'(0));
    chk("rst_fatal", 64'(fat3), 64'(0));
    chk("rst_cnt", 64'(cnt3), 64'(0));
    chk("rst_ready2", 64'(b2.ch_ready_o), 64'(2'b11));
    chk("rst_mask2", 64'(mask2), 64'(0));
    rst = 1'b0;

    // All three agree.
    @(negedge clk);
    set3(3'b111, 32'h100, 32'hDEADBEEF, 32'h100, 32'hDEADBEEF,
         32'h100, 32'hDEADBEEF);
    @(negedge clk); b3.ch_valid_i = '0;
    @(negedge clk);
    chk("t1_valid", 64'(b3.out_valid_o), 64'(1));
    chk("t1_addr", 64'(b3.out_addr_o), 64'(32'h100));
    chk("t1_data", 64'(b3.out_data_o), 64'(32'hDEADBEEF));
    chk("t1_mask", 64'(mask3), 64'(0));
    chk("t1_cnt", 64'(cnt3), 64'(0));

    // Channel 1 corrupt data: masked.
    @(negedge clk);
    set3(3'b111, 32'h104, 32'hDEADBEEF, 32'h104, 32'hDEADBEEE,
         32'h104, 32'hDEADBEEF);
    @(negedge clk); b3.ch_valid_i = '0;
    @(negedge clk);
    chk("t2_valid", 64'(b3.out_valid_o), 64'(1));
    chk("t2_data", 64'(b3.out_data_o), 64'(32'hDEADBEEF));
    chk("t2_mask", 64'(mask3), 64'(3'b010));
    chk("t2_fatal", 64'(fat3), 64'(0));
    chk("t2_cnt", 64'(cnt3), 64'(STATS ? 1 : 0));
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("t2_clr_mask", 64'(mask3), 64'(0));
    chk("t2_clr_cnt", 64'(cnt3), 64'(0));

    // DMR: address mismatch, no majority.
    @(negedge clk);
    b2.ch_valid_i = 2'b11;
    b2.ch_addr_i  = {32'h104, 32'h100};
    b2.ch_data_i  = {32'h55, 32'h55};
    @(negedge clk); b2.ch_valid_i = '0;
    @(negedge clk);
    chk("t3_valid", 64'(b2.out_valid_o), 64'(0));
    chk("t3_fatal", 64'(fat2), 64'(1));
    chk("t3_tmo", 64'(tmo2), 64'(0));
    chk("t3_cnt", 64'(cnt2), 64'(STATS ? 1 : 0));
    b2.ch_valid_i = 2'b11;
    b2.ch_addr_i  = {32'h108, 32'h108};
    b2.ch_data_i  = {32'h5, 32'h5};
    @(negedge clk); b2.ch_valid_i = '0;
    @(negedge clk);
    chk("t3_next_valid", 64'(b2.out_valid_o), 64'(1));
    chk("t3_next_addr", 64'(b2.out_addr_o), 64'(32'h108));
    chk("t3_next_data", 64'(b2.out_data_o), 64'(32'h5));

    // Channel 2 silent: skew timeout.
    @(negedge clk);
    set3(3'b011, 32'h200, 32'h11111111, 32'h200, 32'h11111111,
         32'h0, 32'h0);
    @(negedge clk); b3.ch_valid_i = '0;
    cyc = 0;
    while (!b3.out_valid_o && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    chk("t4_latency", 64'(cyc), 64'(9));
    chk("t4_addr", 64'(b3.out_addr_o), 64'(32'h200));
    chk("t4_mask", 64'(mask3), 64'(3'b100));
    chk("t4_tmo", 64'(tmo3), 64'(1));
    @(negedge clk);
    chk("t4_tmo_end", 64'(tmo3), 64'(0));

    // clr together with a new fault on channel 0.
    @(negedge clk);
    set3(3'b111, 32'h300, 32'hBAD, 32'h300, 32'h600D,
         32'h300, 32'h600D);
    @(negedge clk); b3.ch_valid_i = '0; clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("t6_data", 64'(b3.out_data_o), 64'(32'h600D));
    chk("t6_mask", 64'(mask3), 64'(3'b001));
    chk("t6_fatal", 64'(fat3), 64'(0));
    chk("t6_cnt", 64'(cnt3), 64'(STATS ? 1 : 0));

    // Back-pressure: fill FIFOs behind a held output.
    @(negedge clk);
    b3.out_ready_i = 1'b0;
    for (int s = 0; s < 5; s++) begin
      set3(3'b111, 32'h400 + 4*s, 32'hA0 + s, 32'h400 + 4*s,
           32'hA0 + s, 32'h400 + 4*s, 32'hA0 + s);
      @(negedge clk);
    end
    b3.ch_valid_i = '0;
    chk("t5_full", 64'(b3.ch_ready_o), 64'(3'b000));
    chk("t5_hold_addr", 64'(b3.out_addr_o), 64'(32'h400));
    repeat (3) @(negedge clk);
    chk("t5_hold_valid", 64'(b3.out_valid_o), 64'(1));
    chk("t5_hold_data", 64'(b3.out_data_o), 64'(32'hA0));
    // Release; a push into full ch0 on the same edge must be refused.
    b3.out_ready_i = 1'b1;
    set3(3'b001, 32'h4FC, 32'hFF, 32'h0, 32'h0, 32'h0, 32'h0);
    for (int s = 0; s < 5; s++) begin
      chk("t5_drain_valid", 64'(b3.out_valid_o), 64'(1));
      chk("t5_drain_addr", 64'(b3.out_addr_o), 64'(32'h400 + 4*s));
      @(negedge clk);
      b3.ch_valid_i = '0;
    end
    chk("t5_drain_end", 64'(b3.out_valid_o), 64'(0));

    // Reset in the middle of held and buffered traffic.
    @(negedge clk);
    b3.out_ready_i = 1'b0;
    set3(3'b111, 32'h500, 32'hC0, 32'h500, 32'hC0, 32'h500, 32'hC0);
    @(negedge clk);
    set3(3'b111, 32'h504, 32'hC1, 32'h504, 32'hC1, 32'h504, 32'hC1);
    @(negedge clk); b3.ch_valid_i = '0;
    chk("t7_pre_valid", 64'(b3.out_valid_o), 64'(1));
    rst = 1'b1;
    #1;
    chk("t7_valid", 64'(b3.out_valid_o), 64'(0));
    chk("t7_addr", 64'(b3.out_addr_o), 64'(0));
    chk("t7_data", 64'(b3.out_data_o), 64'(0));
    chk("t7_ready", 64'(b3.ch_ready_o), 64'(3'b111));
    chk("t7_mask", 64'(mask3), 64'(0));
    chk("t7_cnt", 64'(cnt3), 64'(0));
    chk("t7_fatal2", 64'(fat2), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    b3.out_ready_i = 1'b1;
    repeat (12) @(negedge clk);
    chk("t7_quiet", 64'(b3.out_valid_o), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
